// File: rtl/block_accumulator.sv
// Consumes one streamed product block and reduces it to an unsigned sum and a maximum.
// The result is held under a valid/ready handshake until downstream accepts it.
module block_accumulator #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 64,
  parameter int CNT_W   = $clog2(DEPTH) + 1,
  parameter int SUM_W   = DATA_W + $clog2(DEPTH),
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_full,
  output logic              EN_blockRead,
  input  logic              VALID_memVal,
  input  logic [DATA_W-1:0] memVal_data,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [DATA_W-1:0] max_out,
  output logic              err_timeout
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    word_cnt, word_cnt_next;
  logic [STALL_W-1:0]  stall_cnt, stall_cnt_next;
  logic [SUM_W-1:0]    sum_next;
  logic [DATA_W-1:0]   max_next;
  logic                err_next;

  // Next-state and datapath update; sum_out/max_out double as the accumulators.
  always_comb begin
    state_next     = state;
    word_cnt_next  = word_cnt;
    stall_cnt_next = stall_cnt;
    sum_next       = sum_out;
    max_next       = max_out;
    err_next       = 1'b0;
    case (state)
      IDLE: begin
        if (start && src_full) begin
          state_next     = REQ;
          word_cnt_next  = '0;
          stall_cnt_next = '0;
          sum_next       = '0;
          max_next       = '0;
        end else begin
          state_next = IDLE;
        end
      end
      REQ, ACCUM: begin
        if (VALID_memVal) begin
          sum_next       = sum_out + SUM_W'(memVal_data);
          max_next       = (memVal_data > max_out) ? memVal_data : max_out;
          word_cnt_next  = word_cnt + CNT_W'(1);
          stall_cnt_next = '0;
          state_next     = (word_cnt == CNT_W'(DEPTH - 1)) ? DONE : ACCUM;
        end else if (state == REQ) begin
          // The request cycle itself is not counted as a stall.
          state_next = ACCUM;
        end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
          state_next     = IDLE;
          err_next       = 1'b1;
          word_cnt_next  = '0;
          stall_cnt_next = '0;
          sum_next       = '0;
          max_next       = '0;
        end else begin
          stall_cnt_next = stall_cnt + STALL_W'(1);
          state_next     = ACCUM;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      stall_cnt    <= '0;
      sum_out      <= '0;
      max_out      <= '0;
      EN_blockRead <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      word_cnt     <= word_cnt_next;
      stall_cnt    <= stall_cnt_next;
      sum_out      <= sum_next;
      max_out      <= max_next;
      EN_blockRead <= (state_next == REQ);
      busy         <= (state_next != IDLE);
      result_valid <= (state_next == DONE);
      err_timeout  <= err_next;
    end
  end

endmodule

// File: tb/tb_block_accumulator.sv
// Directed-plus-random bench for block_accumulator; expected results come from a
// queue-based reference that sums and maximises the words it drove.
module tb_block_accumulator;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int SUM_W  = 22;

  logic              clk = 1'b0;
  logic              rst, start, src_full, VALID_memVal, result_ready;
  logic [DATA_W-1:0] memVal_data;
  logic              EN_blockRead, busy, result_valid, err_timeout;
  logic [SUM_W-1:0]  sum_out;
  logic [DATA_W-1:0] max_out;

  int checks = 0, errors = 0;
  int en_pulses = 0, err_pulses = 0;
  logic [DATA_W-1:0] words[$];
  int gaps[$];

  block_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .src_full(src_full),
    .EN_blockRead(EN_blockRead), .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .sum_out(sum_out), .max_out(max_out), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (EN_blockRead) en_pulses++;
    if (err_timeout) err_pulses++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain sum and maximum over the words of the block.
  task automatic model(output logic [31:0] s, output logic [31:0] m);
    s = 0;
    m = 0;
    foreach (words[i]) begin
      s += 32'(words[i]);
      if (32'(words[i]) > m) m = 32'(words[i]);
    end
  endtask

  task automatic gen(input int kind);
    words.delete();
    gaps.delete();
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0:       words.push_back(16'(i + 1));
        1:       words.push_back(16'hFFFF);
        default: words.push_back(16'($urandom()));
      endcase
      if (kind == 3 || kind == 4)
        gaps.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0);
      else
        gaps.push_back(0);
    end
    if (kind == 4) begin
      for (int i = 0; i < DEPTH; i++) words[i] = 16'(i + 1);
    end
  endtask

  task automatic begin_block(input string tag, input bit hold_start);
    start = 1'b1;
    src_full = 1'b1;
    cyc();
    chk({tag, "_en_req"}, 32'(EN_blockRead), 32'd1);
    chk({tag, "_busy_req"}, 32'(busy), 32'd1);
    if (!hold_start) start = 1'b0;
    cyc();
    chk({tag, "_en_once"}, 32'(EN_blockRead), 32'd0);
  endtask

  task automatic feed(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (gaps[i]) begin
        VALID_memVal = 1'b0;
        cyc();
      end
      VALID_memVal = 1'b1;
      memVal_data = words[i];
      cyc();
      if (n == DEPTH && i == DEPTH - 2) chk({tag, "_rv_early"}, 32'(result_valid), 32'd0);
    end
    VALID_memVal = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [31:0] s, m;
    model(s, m);
    chk({tag, "_rv"}, 32'(result_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum_out), s);
    chk({tag, "_max"}, 32'(max_out), m);
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic accept(input string tag);
    result_ready = 1'b1;
    cyc();
    chk({tag, "_rv_drop"}, 32'(result_valid), 32'd0);
    result_ready = 1'b0;
  endtask

  initial begin
    int en_base, err_base;
    logic [31:0] s_exp, m_exp;
    rst = 1'b1; start = 1'b0; src_full = 1'b0; VALID_memVal = 1'b0;
    result_ready = 1'b0; memVal_data = '0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(EN_blockRead), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_max", 32'(max_out), 32'd0);
    rst = 1'b0;

    // start without src_full stays idle
    start = 1'b1;
    repeat (3) cyc();
    chk("nofull_busy", 32'(busy), 32'd0);
    chk("nofull_en", 32'(en_pulses), 32'd0);
    start = 1'b0;

    // T1: ramp 1..64 back to back
    gen(0);
    en_base = en_pulses;
    begin_block("t1", 1'b0);
    feed("t1", DEPTH);
    check_result("t1");
    chk("t1_en_count", 32'(en_pulses - en_base), 32'd1);
    accept("t1");
    model(s_exp, m_exp);
    VALID_memVal = 1'b1;
    memVal_data = 16'h1234;
    repeat (3) cyc();
    VALID_memVal = 1'b0;
    chk("idle_valid_sum", 32'(sum_out), s_exp);
    chk("idle_valid_busy", 32'(busy), 32'd0);

    // T2: all ones
    gen(1);
    begin_block("t2", 1'b0);
    feed("t2", DEPTH);
    check_result("t2");
    chk("t2_sum_const", 32'(sum_out), 32'h003F_FFC0);
    accept("t2");

    // T3: ramp with bubbles, then random data with bubbles
    err_base = err_pulses;
    gen(4);
    begin_block("t3", 1'b0);
    feed("t3", DEPTH);
    check_result("t3");
    accept("t3");
    for (int b = 0; b < 2; b++) begin
      gen(3);
      begin_block("t3r", 1'b0);
      feed("t3r", DEPTH);
      check_result("t3r");
      accept("t3r");
    end
    chk("t3_no_err", 32'(err_pulses - err_base), 32'd0);

    // T4: stall timeout after 10 words
    gen(2);
    err_base = err_pulses;
    begin_block("t4", 1'b0);
    feed("t4", 10);
    repeat (15) cyc();
    chk("t4_err_early", 32'(err_timeout), 32'd0);
    chk("t4_busy_early", 32'(busy), 32'd1);
    cyc();
    chk("t4_err", 32'(err_timeout), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_rv", 32'(result_valid), 32'd0);
    chk("t4_sum", 32'(sum_out), 32'd0);
    chk("t4_max", 32'(max_out), 32'd0);
    cyc();
    chk("t4_err_pulse", 32'(err_timeout), 32'd0);
    chk("t4_err_count", 32'(err_pulses - err_base), 32'd1);

    // T5: downstream back-pressure with start held high
    gen(2);
    en_base = en_pulses;
    begin_block("t5", 1'b1);
    feed("t5", DEPTH);
    check_result("t5");
    model(s_exp, m_exp);
    for (int k = 0; k < 5; k++) begin
      VALID_memVal = 1'b1;
      memVal_data = 16'($urandom());
      cyc();
      chk("t5_hold_rv", 32'(result_valid), 32'd1);
      chk("t5_hold_sum", 32'(sum_out), s_exp);
      chk("t5_hold_max", 32'(max_out), m_exp);
    end
    VALID_memVal = 1'b0;
    chk("t5_en_count", 32'(en_pulses - en_base), 32'd1);
    accept("t5");
    cyc();
    chk("t5_next_req", 32'(EN_blockRead), 32'd1);
    start = 1'b0;
    gen(2);
    cyc();
    feed("t5b", DEPTH);
    check_result("t5b");
    accept("t5b");

    // T6: reset mid-block, then a clean block
    gen(2);
    err_base = err_pulses;
    begin_block("t6", 1'b0);
    feed("t6", 30);
    rst = 1'b1;
    cyc();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rv", 32'(result_valid), 32'd0);
    chk("t6_sum", 32'(sum_out), 32'd0);
    chk("t6_max", 32'(max_out), 32'd0);
    chk("t6_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    cyc();
    gen(3);
    begin_block("t6b", 1'b0);
    feed("t6b", DEPTH);
    check_result("t6b");
    accept("t6b");
    chk("t6_err_count", 32'(err_pulses - err_base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
